// File: rtl/vpu_tile_sched.sv
// Job sequencer for the tiled matmul VPU: clears the result grid, streams operand fetches,
// times grid stores against the datapath latency, then unloads the result rows.
module vpu_tile_sched #(
  parameter int ROW_A     = 4,
  parameter int COL_W     = 4,
  parameter int K_TILES   = 2,
  parameter int FETCH_LAT = 1,
  parameter int PIPE_LAT  = 3,
  localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1,
  localparam int RW = (ROW_A > 1) ? $clog2(ROW_A) : 1,
  localparam int CW = $clog2(COL_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             op_valid,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [KW+RW-1:0] a_addr,
  output logic [KW+CW-1:0] w_addr,
  output logic             reset_sys,
  output logic             store,
  output logic             compute_done,
  output logic             deload_out,
  output logic             out_valid,
  output logic [RW-1:0]    out_row
);

  localparam int DL = FETCH_LAT + PIPE_LAT;
  localparam logic [KW-1:0] K_LAST = KW'(K_TILES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROW_A - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COL_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_UNLOAD, S_FIN
  } state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg;
  logic [RW-1:0]   r_reg;
  logic [CW-1:0]   c_reg;
  logic [RW-1:0]   row_cnt_reg;
  logic [DL-1:0]   dl_reg, dl_next;
  logic            out_valid_reg;
  logic [RW-1:0]   out_row_reg;
  logic            issue;
  logic            abort_act;
  logic            last_issue;

  assign abort_act  = abort && (state_reg != S_IDLE);
  assign issue      = (state_reg == S_ISSUE) && op_valid;
  assign last_issue = issue && (k_reg == K_LAST) && (r_reg == R_LAST) && (c_reg == C_LAST);

  always_comb begin
    state_next   = state_reg;
    busy         = (state_reg != S_IDLE);
    done         = 1'b0;
    reset_sys    = 1'b0;
    rd_en        = 1'b0;
    compute_done = 1'b0;
    deload_out   = 1'b0;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_CLEAR;
      S_CLEAR: begin
        reset_sys  = 1'b1;
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en = op_valid;
        if (last_issue) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (dl_reg == '0) begin
          compute_done = 1'b1;
          state_next   = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        deload_out = 1'b1;
        if (row_cnt_reg == R_LAST) state_next = S_FIN;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
    // An abort wins over any completion pulse in the same cycle
    if (abort_act) begin
      state_next   = S_IDLE;
      done         = 1'b0;
      compute_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Issue counters: k outer, row/col of the grid element inner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg <= '0;
      r_reg <= '0;
      c_reg <= '0;
    end else if (abort_act || state_reg == S_CLEAR) begin
      k_reg <= '0;
      r_reg <= '0;
      c_reg <= '0;
    end else if (issue) begin
      if (c_reg == C_LAST) begin
        c_reg <= '0;
        if (r_reg == R_LAST) begin
          r_reg <= '0;
          k_reg <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
        end else begin
          r_reg <= r_reg + 1'b1;
        end
      end else begin
        c_reg <= c_reg + 1'b1;
      end
    end
  end

  assign a_addr = {k_reg, r_reg};
  assign w_addr = {k_reg, c_reg};

  // Store delay line: one tap per cycle of fetch + datapath latency
  assign dl_next[0] = issue && !abort_act;
  for (genvar gi = 1; gi < DL; gi++) begin : g_dl
    assign dl_next[gi] = abort_act ? 1'b0 : dl_reg[gi-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dl_reg <= '0;
    else          dl_reg <= dl_next;
  end

  assign store = dl_reg[DL-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_row_reg   <= '0;
    end else begin
      if (deload_out && !abort_act)
        row_cnt_reg <= (row_cnt_reg == R_LAST) ? '0 : row_cnt_reg + 1'b1;
      else
        row_cnt_reg <= '0;
      out_valid_reg <= deload_out && !abort_act;
      out_row_reg   <= (deload_out && !abort_act) ? row_cnt_reg : '0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_row   = out_row_reg;

endmodule

// File: tb/tb_vpu_tile_sched.sv
// Randomized self-checking bench for vpu_tile_sched: a per-job event log is compared
// against an expected schedule derived from the issue/latency rules.
module tb_vpu_tile_sched;
  localparam int RA = 4, CWD = 4, KT = 2, LAT = 4, NE = RA * CWD * KT;

  logic clk = 1'b0;
  logic reset_n, start, abort, op_valid;
  logic busy, done, rd_en, reset_sys, store, compute_done, deload_out, out_valid;
  logic [2:0] a_addr, w_addr;
  logic [1:0] out_row;

  logic s_start, s_abort;
  logic s_busy, s_done, s_rd_en, s_reset_sys, s_store, s_compute_done, s_deload_out, s_out_valid;
  logic [1:0] s_a_addr, s_w_addr;
  logic       s_out_row;

  logic [15:0] outs;
  logic [12:0] s_outs;
  assign outs   = {busy, done, rd_en, a_addr, w_addr, reset_sys, store, compute_done,
                   deload_out, out_valid, out_row};
  assign s_outs = {s_busy, s_done, s_rd_en, s_a_addr, s_w_addr, s_reset_sys, s_store,
                   s_compute_done, s_deload_out, s_out_valid, s_out_row};

  vpu_tile_sched #(.ROW_A(4), .COL_W(4), .K_TILES(2), .FETCH_LAT(1), .PIPE_LAT(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .op_valid(op_valid),
    .busy(busy), .done(done), .rd_en(rd_en), .a_addr(a_addr), .w_addr(w_addr),
    .reset_sys(reset_sys), .store(store), .compute_done(compute_done),
    .deload_out(deload_out), .out_valid(out_valid), .out_row(out_row));

  vpu_tile_sched #(.ROW_A(2), .COL_W(2), .K_TILES(1), .FETCH_LAT(1), .PIPE_LAT(3)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .abort(s_abort), .op_valid(op_valid),
    .busy(s_busy), .done(s_done), .rd_en(s_rd_en), .a_addr(s_a_addr), .w_addr(s_w_addr),
    .reset_sys(s_reset_sys), .store(s_store), .compute_done(s_compute_done),
    .deload_out(s_deload_out), .out_valid(s_out_valid), .out_row(s_out_row));

  always #5 clk = ~clk;

  int cyc, checks, errors, dlo_n;
  int rd_q[$], a_q[$], w_q[$], st_q[$], cd_q[$], ov_q[$], row_q[$], dn_q[$], rs_q[$];
  int s_rd_q[$], s_a_q[$], s_w_q[$], s_st_q[$], s_row_q[$], s_dn_q[$];
  bit ovh [0:16383];

  // One clock: log what the DUTs show this cycle, then move just past the next edge
  task automatic tick();
    @(negedge clk);
    if (cyc < 16384) ovh[cyc] = op_valid;
    if (rd_en) begin rd_q.push_back(cyc); a_q.push_back(int'(a_addr)); w_q.push_back(int'(w_addr)); end
    if (store) st_q.push_back(cyc);
    if (compute_done) cd_q.push_back(cyc);
    if (out_valid) begin ov_q.push_back(cyc); row_q.push_back(int'(out_row)); end
    if (done) dn_q.push_back(cyc);
    if (reset_sys) rs_q.push_back(cyc);
    if (deload_out) dlo_n++;
    if (s_rd_en) begin s_rd_q.push_back(cyc); s_a_q.push_back(int'(s_a_addr)); s_w_q.push_back(int'(s_w_addr)); end
    if (s_store) s_st_q.push_back(cyc);
    if (s_out_valid) s_row_q.push_back(int'(s_out_row));
    if (s_done) s_dn_q.push_back(cyc);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    rd_q.delete(); a_q.delete(); w_q.delete(); st_q.delete(); cd_q.delete();
    ov_q.delete(); row_q.delete(); dn_q.delete(); rs_q.delete(); dlo_n = 0;
    s_rd_q.delete(); s_a_q.delete(); s_w_q.delete(); s_st_q.delete(); s_row_q.delete(); s_dn_q.delete();
  endtask

  function automatic logic pick(input int mode, input int s);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((cyc - s) % 2) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic test_reset();
    checks++;
    if (outs !== 16'h0) begin errors++; $display("FAIL reset_outs got %h want 0000", outs); end
    checks++;
    if (s_outs !== 13'h0) begin errors++; $display("FAIL reset_outs_small got %h want 0000", s_outs); end
  endtask

  // Full job; expected schedule built from the op_valid history the bench drove
  task automatic test_job(input int mode, input string name);
    int s, tmo, cd_exp, bad;
    int exp_rd[$];
    clear_logs();
    s = cyc;
    start = 1'b1; op_valid = pick(mode, s);
    tick();
    start = 1'b0;
    tmo = 0;
    while (dn_q.size() == 0 && tmo < 500) begin
      op_valid = pick(mode, s); tick(); tmo++;
    end
    repeat (6) begin op_valid = pick(mode, s); tick(); end
    checks++;
    if (tmo >= 500) begin errors++; $display("FAIL %s timeout got no done want done", name); end
    for (int c = s + 2; c < cyc && exp_rd.size() < NE; c++) if (ovh[c]) exp_rd.push_back(c);
    checks++;
    if (rd_q.size() != NE || exp_rd.size() != NE) begin
      errors++; $display("FAIL %s rd_count got %0d want %0d", name, rd_q.size(), NE);
    end else begin
      bad = -1;
      for (int i = 0; i < NE; i++) if (rd_q[i] != exp_rd[i] && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL %s rd_cycle[%0d] got %0d want %0d", name, bad, rd_q[bad], exp_rd[bad]); end
      bad = -1;
      for (int i = 0; i < NE; i++)
        if ((a_q[i] != (i / 16) * 4 + (i % 16) / 4 || w_q[i] != (i / 16) * 4 + i % 4) && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s addr[%0d] got a=%0d w=%0d want a=%0d w=%0d", name, bad, a_q[bad], w_q[bad],
                 (bad / 16) * 4 + (bad % 16) / 4, (bad / 16) * 4 + bad % 4);
      end
      bad = (st_q.size() == NE) ? -1 : 0;
      if (bad < 0) for (int i = 0; i < NE; i++) if (st_q[i] != exp_rd[i] + LAT && bad < 0) bad = i + 1;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL %s stores got %0d stores (bad idx %0d) want %0d at rd+%0d", name, st_q.size(), bad, NE, LAT); end
      cd_exp = exp_rd[NE-1] + LAT + 1;
      checks++;
      if (rs_q.size() != 1 || rs_q[0] != s + 1) begin
        errors++; $display("FAIL %s reset_sys got %0d pulses want 1 at %0d", name, rs_q.size(), s + 1);
      end
      checks++;
      if (cd_q.size() != 1 || cd_q[0] != cd_exp) begin
        errors++; $display("FAIL %s compute_done got %0d pulses want 1 at %0d", name, cd_q.size(), cd_exp);
      end
      bad = (ov_q.size() == RA) ? -1 : 0;
      if (bad < 0) for (int i = 0; i < RA; i++) if ((ov_q[i] != cd_exp + 2 + i || row_q[i] != i) && bad < 0) bad = i + 1;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL %s out_rows got %0d beats (bad %0d) want rows 0..%0d from %0d", name, ov_q.size(), bad, RA - 1, cd_exp + 2); end
      checks++;
      if (dn_q.size() != 1 || dn_q[0] != cd_exp + 1 + RA) begin
        errors++; $display("FAIL %s done got %0d pulses want 1 at %0d", name, dn_q.size(), cd_exp + 1 + RA);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    $display("job %s: start=%0d issues=%0d stores=%0d rows=%0d", name, s, rd_q.size(), st_q.size(), ov_q.size());
  endtask

  task automatic test_abort();
    int s, tmo, ac, late;
    clear_logs();
    s = cyc;
    start = 1'b1; op_valid = 1'b1;
    tick();
    start = 1'b0;
    tmo = 0;
    while (rd_q.size() < 10 && tmo < 100) begin tick(); tmo++; end
    ac = cyc;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, rd_en, store, deload_out, out_valid} !== 5'b0) begin
      errors++; $display("FAIL abort_next got busy=%b rd=%b store=%b want all 0", busy, rd_en, store);
    end
    repeat (20) tick();
    late = 0;
    foreach (st_q[i]) if (st_q[i] > ac) late++;
    checks++;
    if (late != 0) begin errors++; $display("FAIL abort_stores got %0d late stores want 0", late); end
    checks++;
    if (cd_q.size() != 0 || dn_q.size() != 0 || ov_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet got cd=%0d done=%0d ov=%0d busy=%b want 0 0 0 0", cd_q.size(), dn_q.size(), ov_q.size(), busy);
    end
    $display("abort at cycle %0d after %0d issues", ac, rd_q.size());
  endtask

  task automatic test_reset_unload();
    int tmo;
    clear_logs();
    start = 1'b1; op_valid = 1'b1;
    tick();
    start = 1'b0;
    tmo = 0;
    while (dlo_n < 2 && tmo < 200) begin tick(); tmo++; end
    checks++;
    if (deload_out !== 1'b1) begin errors++; $display("FAIL unload_reach got deload=%b want 1", deload_out); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== 16'h0) begin errors++; $display("FAIL async_reset got %h want 0000", outs); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    $display("reset during unload row 2, outputs %h", outs);
  endtask

  task automatic test_small();
    int s, tmo, bad;
    clear_logs();
    s = cyc;
    s_start = 1'b1; op_valid = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (3) tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tmo = 0;
    while (s_dn_q.size() == 0 && tmo < 100) begin tick(); tmo++; end
    repeat (15) tick();
    checks++;
    if (s_rd_q.size() != 4) begin errors++; $display("FAIL small_rd_count got %0d want 4", s_rd_q.size()); end
    else begin
      bad = -1;
      for (int i = 0; i < 4; i++)
        if ((s_rd_q[i] != s + 2 + i || s_a_q[i] != i / 2 || s_w_q[i] != i % 2) && bad < 0) bad = i;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL small_issue[%0d] got cyc=%0d a=%0d w=%0d want cyc=%0d a=%0d w=%0d", bad, s_rd_q[bad], s_a_q[bad], s_w_q[bad], s + 2 + bad, bad / 2, bad % 2); end
    end
    bad = (s_st_q.size() == 4) ? -1 : 0;
    if (bad < 0) for (int i = 0; i < 4; i++) if (s_st_q[i] != s + 2 + i + LAT && bad < 0) bad = i + 1;
    checks++;
    if (bad >= 0) begin errors++; $display("FAIL small_stores got %0d (bad %0d) want 4 at rd+%0d", s_st_q.size(), bad, LAT); end
    checks++;
    if (s_row_q.size() != 2 || s_row_q[0] != 0 || s_row_q[1] != 1) begin
      errors++; $display("FAIL small_rows got %0d beats want rows 0,1", s_row_q.size());
    end
    checks++;
    if (s_dn_q.size() != 1 || s_dn_q[0] != s + 13) begin
      errors++; $display("FAIL small_done got %0d pulses want 1 at %0d", s_dn_q.size(), s + 13);
    end
    $display("small job: issues=%0d stores=%0d rows=%0d done=%0d", s_rd_q.size(), s_st_q.size(), s_row_q.size(), s_dn_q.size());
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0;
    s_start = 1'b0; s_abort = 1'b0;
    cyc = 0; checks = 0; errors = 0; dlo_n = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    repeat (2) tick();
    test_job(0, "full_rate");
    test_job(1, "stall_toggle");
    test_job(2, "random_a");
    test_job(2, "random_b");
    test_abort();
    test_job(0, "after_abort");
    test_reset_unload();
    test_job(2, "after_reset");
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
